// File: rtl/fetch_pkg.sv
// Shared constants and entry type for the instruction-fetch queue.
package fetch_pkg;

    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } fetch_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// Synchronous circular buffer with flush and occupancy count.
module fq_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  entry_t                 wdata_i,
    output entry_t                 rdata_o,
    output logic [$clog2(DEPTH):0] occ_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     occ_q, occ_d;
    logic               do_push, do_pop;

    always_comb begin
        do_push  = push_i && !flush_i && (occ_q != FULL);
        do_pop   = pop_i && !flush_i && (occ_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            occ_d = occ_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign rdata_o = (occ_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign occ_o   = occ_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order memory
// requests and buffers returned instructions for decode.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     redirect_i,
    input  logic [ADDR_W-1:0]        redirect_pc_i,
    output logic                     imem_req_o,
    output logic [ADDR_W-1:0]        imem_addr_o,
    input  logic                     imem_valid_i,
    input  logic [DATA_W-1:0]        imem_rdata_i,
    output logic                     dec_valid_o,
    output logic [DATA_W-1:0]        dec_inst_o,
    output logic [ADDR_W-1:0]        dec_pc4_o,
    input  logic                     dec_ready_i,
    output logic [$clog2(DEPTH):0]   occ_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]      LIMIT = (CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0]   STEP  = ADDR_W'(PC_STEP);

    typedef logic [DATA_W+ADDR_W-1:0] slot_t;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ret_pc_q, ret_pc_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [CNT_W-1:0]  occ;
    logic [CNT_W:0]    pending;
    logic              issue, resp, push, pop;
    slot_t             wdata, rdata;

    // ret_pc_q tracks the address of the next response that will be kept;
    // dropped responses do not advance it.
    always_comb begin
        pending    = {1'b0, occ} + {1'b0, inflight_q};
        issue      = rst_i && start_i && !redirect_i && (pending < LIMIT);
        resp       = imem_valid_i && (inflight_q != '0);
        push       = resp && (drop_q == '0) && !redirect_i;
        pop        = (occ != '0) && dec_ready_i;
        inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(resp);
        wdata      = {imem_rdata_i, ret_pc_q + STEP};
        pc_d       = pc_q;
        ret_pc_d   = ret_pc_q;
        drop_d     = drop_q;
        if (redirect_i) begin
            pc_d     = redirect_pc_i;
            ret_pc_d = redirect_pc_i;
            drop_d   = inflight_q - CNT_W'(resp);
        end else begin
            if (issue) begin
                pc_d = pc_q + STEP;
            end
            if (push) begin
                ret_pc_d = ret_pc_q + STEP;
            end else if (resp && (drop_q != '0)) begin
                drop_d = drop_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pc_q       <= RESET_PC;
            ret_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            ret_pc_q   <= ret_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    fq_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (slot_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .occ_o   (occ)
    );

    assign imem_req_o              = issue;
    assign imem_addr_o             = pc_q;
    assign dec_valid_o             = (occ != '0);
    assign {dec_inst_o, dec_pc4_o} = rdata;
    assign occ_o                   = occ;

    resp_without_request: assert property (
        @(posedge clk_i) disable iff (!rst_i) !(imem_valid_i && (inflight_q == '0))
    );

endmodule
